branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences branch_predictor training and pipeline recovery. Keeps in-order queue of branches
//  decoded with their prediction; on EXEC resolution pops oldest, drives predictor update
//  (pc/target/outcome) and, on mispredict, redirects fetch and flushes F/D for a fixed window.
//  Sits between DECODE, EXEC and branch_predictor.
// PARAMETERS
//  ADDR_W        32  PC / target width
//  DEPTH         4   in-flight branch queue entries; power of 2, >=2
//  FLUSH_CYCLES  2   cycles flush held after mispredict; >=1
// PORTS
//  clk             in   1              clock, rising edge
//  rst             in   1              asynchronous reset, active-high
//  d_valid         in   1              DECODE holds valid instruction
//  d_is_branch     in   1              DECODE instruction is a branch
//  d_pc            in   ADDR_W         DECODE PC
//  d_target_addr   in   ADDR_W         DECODE computed branch target
//  d_pred_taken    in   1              prediction used at fetch (f_predict_valid carried to D)
//  x_br_valid      in   1              EXEC resolves oldest outstanding branch this cycle
//  x_br_taken      in   1              resolved outcome
//  q_full          out  1              queue full; DECODE stalls branches
//  q_count         out  $clog2(DEPTH+1) entries outstanding
//  bp_upd_valid    out  1              predictor update strobe (1 cycle)
//  bp_upd_pc       out  ADDR_W         branch PC being trained
//  bp_upd_target   out  ADDR_W         branch target being trained
//  bp_upd_taken    out  1              outcome (predictor x_predict_res)
//  redirect_valid  out  1              fetch redirect pulse (1 cycle)
//  redirect_pc     out  ADDR_W         correct fetch PC
//  flush           out  1              kill younger instructions in F/D
//  err_overflow    out  1              sticky: enqueue attempted while full
//  err_underflow   out  1              sticky: x_br_valid with queue empty in RUN
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, pointers/count 0, state RUN; applies mid-FLUSH too.
//  Entry = {pc, target, pred_taken}. Circular FIFO, rd/wr pointers wrap mod DEPTH.
//  q_full = (count==DEPTH), combinational from count. q_count registered.
//  States: RUN, FLUSH.
//  RUN:
//   - enq = d_valid & d_is_branch. Accepted iff !q_full; full -> dropped, err_overflow<=1
//     (pop same cycle does NOT free slot for that enqueue).
//   - pop = x_br_valid & count!=0. Empty -> ignored, err_underflow<=1.
//   - Latency 1: cycle after pop, bp_upd_valid=1, bp_upd_pc/target=head pc/target,
//     bp_upd_taken=x_br_taken. upd_* hold last value when strobe low.
//   - mispredict = head.pred_taken != x_br_taken. Same edge: queue cleared (count 0, rd=wr),
//     same-cycle enqueue dropped (younger, no err), state->FLUSH, flush<=1,
//     redirect_valid<=1 for one cycle, redirect_pc = taken ? target : pc+4 (mod 2^ADDR_W).
//   - enq+pop without mispredict: both take effect, count unchanged.
//  FLUSH: flush=1 exactly FLUSH_CYCLES cycles (down-counter), first coincident with
//   redirect_valid; enqueues dropped silently; x_br_valid ignored, no err. Then -> RUN, flush=0.
//  Queue order strict FIFO; training never reordered or skipped for resolved branches.
// TESTING
//  1 enq 0x100c tgt 0x1014 pred 0; resolve taken=1 -> next cycle upd(0x100c,0x1014,1),
//    redirect 0x1014, flush high 2 cycles, q_count 0.
//  2 enq 0x1008 tgt 0x1010 pred 0; resolve taken=0 -> upd(0x1008,0x1010,0), no redirect/flush.
//  3 enq 0x1014 tgt 0x1000 pred 1; resolve taken=0 -> redirect_pc 0x1018, flush 2 cycles.
//  4 enq 4 branches -> q_full=1, q_count 4; 5th enq -> err_overflow=1, count 4; enq+pop same
//    cycle at count 2 -> count stays 2.
//  5 x_br_valid on empty -> err_underflow sticky; enqueue during FLUSH -> count stays 0.
//  6 10 alternating enq/resolve pairs (pointer wrap) -> updates in enq order; assert rst
//    mid-FLUSH -> all outputs 0 without waiting for clk edge.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// In-order branch queue between DECODE and EXEC: trains the predictor on resolution
// and, on a mispredict, redirects fetch and holds flush for FLUSH_CYCLES cycles.
module branch_resolve_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       d_valid,
    input  logic                       d_is_branch,
    input  logic [ADDR_W-1:0]          d_pc,
    input  logic [ADDR_W-1:0]          d_target_addr,
    input  logic                       d_pred_taken,
    input  logic                       x_br_valid,
    input  logic                       x_br_taken,
    output logic                       q_full,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       bp_upd_valid,
    output logic [ADDR_W-1:0]          bp_upd_pc,
    output logic [ADDR_W-1:0]          bp_upd_target,
    output logic                       bp_upd_taken,
    output logic                       redirect_valid,
    output logic [ADDR_W-1:0]          redirect_pc,
    output logic                       flush,
    output logic                       err_overflow,
    output logic                       err_underflow
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    logic              state_q, state_d;
    logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
    logic [ADDR_W-1:0] upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
    logic              redir_valid_q, redir_valid_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
    logic              flush_q, flush_d;
    logic              err_ov_q, err_ov_d, err_un_q, err_un_d;

    logic [ADDR_W-1:0] ent_pc_q     [DEPTH];
    logic [ADDR_W-1:0] ent_target_q [DEPTH];
    logic              ent_pred_q   [DEPTH];

    logic              enq, pop, mispredict, enq_ok;
    logic [ADDR_W-1:0] head_pc, head_target;
    logic              head_pred;

    assign head_pc     = ent_pc_q[rd_ptr_q];
    assign head_target = ent_target_q[rd_ptr_q];
    assign head_pred   = ent_pred_q[rd_ptr_q];

    assign enq        = d_valid & d_is_branch;
    assign pop        = (state_q == ST_RUN) & x_br_valid & (count_q != '0);
    assign mispredict = pop & (head_pred != x_br_taken);

    assign q_full = (count_q == CW'(DEPTH));

    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_target_d  = upd_target_q;
        upd_taken_d   = upd_taken_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        flush_d       = flush_q;
        err_ov_d      = err_ov_q;
        err_un_d      = err_un_q;
        enq_ok        = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (enq && q_full)
                    err_ov_d = 1'b1;
                if (x_br_valid && count_q == '0)
                    err_un_d = 1'b1;
                if (pop) begin
                    upd_valid_d  = 1'b1;
                    upd_pc_d     = head_pc;
                    upd_target_d = head_target;
                    upd_taken_d  = x_br_taken;
                end
                if (mispredict) begin
                    // Everything still queued is younger than the bad branch: discard it.
                    count_d       = '0;
                    rd_ptr_d      = wr_ptr_q;
                    state_d       = ST_FLUSH;
                    flush_d       = 1'b1;
                    flush_cnt_d   = FCW'(FLUSH_CYCLES - 1);
                    redir_valid_d = 1'b1;
                    redir_pc_d    = x_br_taken ? head_target : head_pc + ADDR_W'(4);
                end else begin
                    enq_ok = enq & ~q_full;
                    if (enq_ok)
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    if (pop)
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d = count_q + CW'(enq_ok) - CW'(pop);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: queue storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            ent_pc_q[wr_ptr_q]     <= d_pc;
            ent_target_q[wr_ptr_q] <= d_target_addr;
            ent_pred_q[wr_ptr_q]   <= d_pred_taken;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
            upd_taken_q   <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            err_ov_q      <= 1'b0;
            err_un_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_target_q  <= upd_target_d;
            upd_taken_q   <= upd_taken_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            err_ov_q      <= err_ov_d;
            err_un_q      <= err_un_d;
        end
    end

    assign q_count        = count_q;
    assign bp_upd_valid   = upd_valid_q;
    assign bp_upd_pc      = upd_pc_q;
    assign bp_upd_target  = upd_target_q;
    assign bp_upd_taken   = upd_taken_q;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;
    assign flush          = flush_q;
    assign err_overflow   = err_ov_q;
    assign err_underflow  = err_un_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a per-cycle vector table followed by a
// pointer-wrap sequence and an asynchronous reset asserted mid-flush.
module tb_branch_resolve_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid, d_is_branch, d_pred_taken, x_br_valid, x_br_taken;
    logic [31:0] d_pc, d_target_addr;
    logic        q_full, bp_upd_valid, bp_upd_taken, redirect_valid, flush;
    logic        err_overflow, err_underflow;
    logic [2:0]  q_count;
    logic [31:0] bp_upd_pc, bp_upd_target, redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_ctrl #(.ADDR_W(32), .DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .d_valid(d_valid), .d_is_branch(d_is_branch), .d_pc(d_pc),
        .d_target_addr(d_target_addr), .d_pred_taken(d_pred_taken),
        .x_br_valid(x_br_valid), .x_br_taken(x_br_taken),
        .q_full(q_full), .q_count(q_count),
        .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc),
        .bp_upd_target(bp_upd_target), .bp_upd_taken(bp_upd_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // One clock of stimulus and the outputs expected just after that edge.
    typedef struct {
        logic        dv, db;
        logic [31:0] dpc, dtgt;
        logic        dpred, xv, xt;
        logic [2:0]  cnt;
        logic        full, uv;
        logic [31:0] upc, utgt;
        logic        ut, rv;
        logic [31:0] rpc;
        logic        fl, eov, eun;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic xv, input logic xt);
        d_valid = dv; d_is_branch = dv; d_pc = pc; d_target_addr = tgt;
        d_pred_taken = pred; x_br_valid = xv; x_br_taken = xt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " q_count"}, 64'(q_count), 64'd0);
        check({tag, " q_full"}, 64'(q_full), 64'd0);
        check({tag, " upd_valid"}, 64'(bp_upd_valid), 64'd0);
        check({tag, " upd_pc"}, 64'(bp_upd_pc), 64'd0);
        check({tag, " upd_target"}, 64'(bp_upd_target), 64'd0);
        check({tag, " upd_taken"}, 64'(bp_upd_taken), 64'd0);
        check({tag, " redirect_valid"}, 64'(redirect_valid), 64'd0);
        check({tag, " redirect_pc"}, 64'(redirect_pc), 64'd0);
        check({tag, " flush"}, 64'(flush), 64'd0);
        check({tag, " err_overflow"}, 64'(err_overflow), 64'd0);
        check({tag, " err_underflow"}, 64'(err_underflow), 64'd0);
    endtask

    initial begin
        // {dv,db,dpc,dtgt,dpred,xv,xt, cnt,full,uv,upc,utgt,ut,rv,rpc,fl,eov,eun}
        // mispredict taken: redirect to target, flush two cycles
        vecs.push_back('{1,1,'h100c,'h1014,0,0,0, 1,0,0,'h0,'h0,0,0,'h0,0,0,0});
        vecs.push_back('{0,0,'h0,'h0,0,1,1, 0,0,1,'h100c,'h1014,1,1,'h1014,1,0,0});
        vecs.push_back('{0,0,'h0,'h0,0,0,0, 0,0,0,'h100c,'h1014,1,0,'h1014,1,0,0});
        vecs.push_back('{0,0,'h0,'h0,0,0,0, 0,0,0,'h100c,'h1014,1,0,'h1014,0,0,0});
        // correct prediction: train only
        vecs.push_back('{1,1,'h1008,'h1010,0,0,0, 1,0,0,'h100c,'h1014,1,0,'h1014,0,0,0});
        vecs.push_back('{0,0,'h0,'h0,0,1,0, 0,0,1,'h1008,'h1010,0,0,'h1014,0,0,0});
        // mispredict not-taken: redirect to pc+4
        vecs.push_back('{1,1,'h1014,'h1000,1,0,0, 1,0,0,'h1008,'h1010,0,0,'h1014,0,0,0});
        vecs.push_back('{0,0,'h0,'h0,0,1,0, 0,0,1,'h1014,'h1000,0,1,'h1018,1,0,0});
        vecs.push_back('{0,0,'h0,'h0,0,0,0, 0,0,0,'h1014,'h1000,0,0,'h1018,1,0,0});
        vecs.push_back('{0,0,'h0,'h0,0,0,0, 0,0,0,'h1014,'h1000,0,0,'h1018,0,0,0});
        // fill to full, overflow, drain with enq+pop at count 2
        vecs.push_back('{1,1,'h2000,'h3000,0,0,0, 1,0,0,'h1014,'h1000,0,0,'h1018,0,0,0});
        vecs.push_back('{1,1,'h2004,'h3004,0,0,0, 2,0,0,'h1014,'h1000,0,0,'h1018,0,0,0});
        vecs.push_back('{1,1,'h2008,'h3008,0,0,0, 3,0,0,'h1014,'h1000,0,0,'h1018,0,0,0});
        vecs.push_back('{1,1,'h200c,'h300c,0,0,0, 4,1,0,'h1014,'h1000,0,0,'h1018,0,0,0});
        vecs.push_back('{1,1,'h2099,'h3099,0,0,0, 4,1,0,'h1014,'h1000,0,0,'h1018,0,1,0});
        vecs.push_back('{0,0,'h0,'h0,0,1,0, 3,0,1,'h2000,'h3000,0,0,'h1018,0,1,0});
        vecs.push_back('{0,0,'h0,'h0,0,1,0, 2,0,1,'h2004,'h3004,0,0,'h1018,0,1,0});
        vecs.push_back('{1,1,'h2010,'h3010,0,1,0, 2,0,1,'h2008,'h3008,0,0,'h1018,0,1,0});
        vecs.push_back('{0,0,'h0,'h0,0,1,0, 1,0,1,'h200c,'h300c,0,0,'h1018,0,1,0});
        vecs.push_back('{0,0,'h0,'h0,0,1,0, 0,0,1,'h2010,'h3010,0,0,'h1018,0,1,0});
        // resolve on empty queue, then enqueue attempts during flush
        vecs.push_back('{0,0,'h0,'h0,0,1,0, 0,0,0,'h2010,'h3010,0,0,'h1018,0,1,1});
        vecs.push_back('{1,1,'h4000,'h4040,1,0,0, 1,0,0,'h2010,'h3010,0,0,'h1018,0,1,1});
        vecs.push_back('{0,0,'h0,'h0,0,1,0, 0,0,1,'h4000,'h4040,0,1,'h4004,1,1,1});
        vecs.push_back('{1,1,'h5000,'h5040,0,1,1, 0,0,0,'h4000,'h4040,0,0,'h4004,1,1,1});
        vecs.push_back('{1,1,'h5004,'h5044,0,0,0, 0,0,0,'h4000,'h4040,0,0,'h4004,0,1,1});
        vecs.push_back('{0,0,'h0,'h0,0,0,0, 0,0,0,'h4000,'h4040,0,0,'h4004,0,1,1});

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("v%0d", i);
            drive(vecs[i].dv, vecs[i].dpc, vecs[i].dtgt, vecs[i].dpred, vecs[i].xv, vecs[i].xt);
            step();
            check({t, " q_count"}, 64'(q_count), 64'(vecs[i].cnt));
            check({t, " q_full"}, 64'(q_full), 64'(vecs[i].full));
            check({t, " upd_valid"}, 64'(bp_upd_valid), 64'(vecs[i].uv));
            check({t, " upd_pc"}, 64'(bp_upd_pc), 64'(vecs[i].upc));
            check({t, " upd_target"}, 64'(bp_upd_target), 64'(vecs[i].utgt));
            check({t, " upd_taken"}, 64'(bp_upd_taken), 64'(vecs[i].ut));
            check({t, " redirect_valid"}, 64'(redirect_valid), 64'(vecs[i].rv));
            check({t, " redirect_pc"}, 64'(redirect_pc), 64'(vecs[i].rpc));
            check({t, " flush"}, 64'(flush), 64'(vecs[i].fl));
            check({t, " err_overflow"}, 64'(err_overflow), 64'(vecs[i].eov));
            check({t, " err_underflow"}, 64'(err_underflow), 64'(vecs[i].eun));
        end

        // Ten branches, each resolved (correctly predicted) while the next enqueues;
        // walks the pointers past the wrap several times.
        for (int k = 0; k <= 10; k++) begin
            logic [31:0] pc_n, tgt_n, pc_p, tgt_p;
            logic        pred_n, pred_p;
            pc_n  = 32'h6000 + 32'(k) * 8;
            tgt_n = 32'h7000 + 32'(k) * 8;
            pred_n = k[0];
            pc_p  = pc_n - 8;
            tgt_p = tgt_n - 8;
            pred_p = ~k[0];
            drive(k < 10, pc_n, tgt_n, pred_n, k >= 1, pred_p);
            step();
            check($sformatf("wrap%0d q_count", k), 64'(q_count), (k < 10) ? 64'd1 : 64'd0);
            if (k >= 1) begin
                check($sformatf("wrap%0d upd_valid", k), 64'(bp_upd_valid), 64'd1);
                check($sformatf("wrap%0d upd_pc", k), 64'(bp_upd_pc), 64'(pc_p));
                check($sformatf("wrap%0d upd_target", k), 64'(bp_upd_target), 64'(tgt_p));
                check($sformatf("wrap%0d upd_taken", k), 64'(bp_upd_taken), 64'(pred_p));
                check($sformatf("wrap%0d flush", k), 64'(flush), 64'd0);
            end
        end

        // Mispredict, then assert reset between clock edges while flush is high.
        drive(1, 32'h8000, 32'h8100, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        check("midflush flush", 64'(flush), 64'd1);
        check("midflush redirect_pc", 64'(redirect_pc), 64'h8004);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst flush", 64'(flush), 64'd0);
        check("post_rst q_count", 64'(q_count), 64'd0);
        drive(1, 32'h9000, 32'h9100, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        check("post_rst enq q_count", 64'(q_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
